// File: rtl/noc_inject_pkg.sv
// Shared types and width helpers for the NoC injection mux/serializer.
package noc_inject_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } inj_state_e;

  function automatic int flit_width(input int tdata_w, input int sf);
    return tdata_w / sf;
  endfunction

  function automatic int dest_width(input int tid_w, input int tdest_w);
    return tid_w + tdest_w;
  endfunction

  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Index width that stays legal when the indexed set has a single member.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above rr_ptr, wrapping.
module rr_arbiter
  import noc_inject_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  localparam int IDX_W = idx_width(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] req,
  input  logic [IDX_W-1:0]        rr_ptr,
  output logic [NUM_CHANNELS-1:0] gnt,
  output logic [IDX_W-1:0]        gnt_idx,
  output logic                    gnt_vld
);

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % NUM_CHANNELS);
  endfunction

  // Scan from the pointer upward and take the first active request.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (!gnt_vld && req[wrap_idx(int'(rr_ptr) + i)]) begin
        gnt_vld                           = 1'b1;
        gnt[wrap_idx(int'(rr_ptr) + i)]   = 1'b1;
        gnt_idx                           = wrap_idx(int'(rr_ptr) + i);
      end
    end
  end

endmodule

// File: rtl/axis_inject_mux_serializer.sv
// Packet-granular AXIS mux feeding a credit-controlled router port, one flit per cycle.
module axis_inject_mux_serializer
  import noc_inject_pkg::*;
#(
  parameter int NUM_CHANNELS         = 4,
  parameter int TDATA_WIDTH          = 32,
  parameter int TID_WIDTH            = 2,
  parameter int TDEST_WIDTH          = 2,
  parameter int SERIALIZATION_FACTOR = 2,
  parameter int FLIT_BUFFER_DEPTH    = 4,
  localparam int FLIT_WIDTH = flit_width(TDATA_WIDTH, SERIALIZATION_FACTOR),
  localparam int DEST_WIDTH = dest_width(TID_WIDTH, TDEST_WIDTH),
  localparam int CW         = credit_width(FLIT_BUFFER_DEPTH)
) (
  input  logic                                     clk_noc,
  input  logic                                     rst,
  input  logic [NUM_CHANNELS-1:0]                  s_axis_tvalid,
  output logic [NUM_CHANNELS-1:0]                  s_axis_tready,
  input  logic [NUM_CHANNELS-1:0][TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_CHANNELS-1:0]                  s_axis_tlast,
  input  logic [NUM_CHANNELS-1:0][TID_WIDTH-1:0]   s_axis_tid,
  input  logic [NUM_CHANNELS-1:0][TDEST_WIDTH-1:0] s_axis_tdest,
  output logic [FLIT_WIDTH-1:0]                    data_out,
  output logic [DEST_WIDTH-1:0]                    dest_out,
  output logic                                     is_tail_out,
  output logic                                     send_out,
  input  logic                                     credit_in,
  output logic [CW-1:0]                            credit_count,
  output logic                                     credit_overflow
);

  localparam int CH_W   = idx_width(NUM_CHANNELS);
  localparam int FIDX_W = idx_width(SERIALIZATION_FACTOR);
  localparam logic [0:0]        ST_IDLE   = IDLE;
  localparam logic [0:0]        ST_LOCKED = LOCKED;
  localparam logic [FIDX_W-1:0] FIDX_LAST = FIDX_W'(SERIALIZATION_FACTOR - 1);
  localparam logic [CW-1:0]     CR_FULL   = CW'(FLIT_BUFFER_DEPTH);

  logic [0:0]              state;
  logic [CH_W-1:0]         rr_ptr;
  logic [CH_W-1:0]         grant_idx;
  logic [NUM_CHANNELS-1:0] arb_gnt;
  logic [CH_W-1:0]         arb_idx;
  logic                    arb_vld;
  logic [CH_W-1:0]         sel_idx;
  logic                    sel_vld;

  logic [TDATA_WIDTH-1:0]  beat_data_p0;
  logic [DEST_WIDTH-1:0]   beat_dest_p0;
  logic                    beat_last_p0;
  logic                    vld_p0;
  logic [FIDX_W-1:0]       fidx;

  logic launch;
  logic final_launch;
  logic room;
  logic accept;

  rr_arbiter #(.NUM_CHANNELS(NUM_CHANNELS)) u_arb (
    .req     (s_axis_tvalid),
    .rr_ptr  (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  assign launch       = vld_p0 && (credit_count != '0);
  assign final_launch = launch && (fidx == FIDX_LAST);
  assign room         = !vld_p0 || final_launch;
  assign sel_idx      = (state == ST_IDLE) ? arb_idx : grant_idx;
  assign sel_vld      = (state == ST_IDLE) ? arb_vld : 1'b1;
  assign accept       = |(s_axis_tvalid & s_axis_tready);

  // Only the selected channel sees ready, and only when the beat register frees up.
  always_comb begin
    s_axis_tready = '0;
    if (!rst && room && sel_vld) s_axis_tready[sel_idx] = 1'b1;
  end

  // Stage p0: beat register payload, loaded on acceptance.
  always_ff @(posedge clk_noc) begin
    if (accept) begin
      beat_data_p0 <= s_axis_tdata[sel_idx];
      beat_dest_p0 <= {s_axis_tid[sel_idx], s_axis_tdest[sel_idx]};
      beat_last_p0 <= s_axis_tlast[sel_idx];
    end
  end

  // Packet ownership, flit sequencing and the registered flit outputs (stage p1).
  always_ff @(posedge clk_noc) begin
    if (rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      vld_p0      <= 1'b0;
      fidx        <= '0;
      send_out    <= 1'b0;
      is_tail_out <= 1'b0;
      data_out    <= '0;
      dest_out    <= '0;
    end else begin
      send_out <= launch;
      if (launch) begin
        data_out    <= beat_data_p0[fidx*FLIT_WIDTH +: FLIT_WIDTH];
        dest_out    <= beat_dest_p0;
        is_tail_out <= beat_last_p0 && (fidx == FIDX_LAST);
        fidx        <= (fidx == FIDX_LAST) ? '0 : fidx + 1'b1;
      end
      if (accept) begin
        vld_p0 <= 1'b1;
        fidx   <= '0;
        if (s_axis_tlast[sel_idx]) begin
          state  <= ST_IDLE;
          rr_ptr <= (sel_idx == CH_W'(NUM_CHANNELS - 1)) ? '0 : sel_idx + 1'b1;
        end else begin
          state     <= ST_LOCKED;
          grant_idx <= sel_idx;
        end
      end else if (final_launch) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  // Credit counter: launches consume, credit_in returns; excess returns flag overflow.
  always_ff @(posedge clk_noc) begin
    if (rst) begin
      credit_count    <= CR_FULL;
      credit_overflow <= 1'b0;
    end else begin
      case ({launch, credit_in})
        2'b10: credit_count <= credit_count - 1'b1;
        2'b01: begin
          if (credit_count == CR_FULL) credit_overflow <= 1'b1;
          else                         credit_count    <= credit_count + 1'b1;
        end
        default: credit_count <= credit_count;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_inject_mux_serializer.sv
// Scoreboard bench for axis_inject_mux_serializer with default parameters.
module tb_axis_inject_mux_serializer;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  dest;
    logic        tail;
  } flit_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [1:0]  tid;
    logic [1:0]  tdest;
  } beat_t;

  logic             clk_noc = 1'b0;
  logic             rst;
  logic [3:0]       s_axis_tvalid;
  logic [3:0]       s_axis_tready;
  logic [3:0][31:0] s_axis_tdata;
  logic [3:0]       s_axis_tlast;
  logic [3:0][1:0]  s_axis_tid;
  logic [3:0][1:0]  s_axis_tdest;
  logic [15:0]      data_out;
  logic [3:0]       dest_out;
  logic             is_tail_out;
  logic             send_out;
  logic             credit_in;
  logic [2:0]       credit_count;
  logic             credit_overflow;

  flit_t sb[$];
  beat_t chq[4][$];
  int    total = 0;
  int    bad = 0;
  int    send_cnt = 0;

  axis_inject_mux_serializer dut (
    .clk_noc         (clk_noc),
    .rst             (rst),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tid      (s_axis_tid),
    .s_axis_tdest    (s_axis_tdest),
    .data_out        (data_out),
    .dest_out        (dest_out),
    .is_tail_out     (is_tail_out),
    .send_out        (send_out),
    .credit_in       (credit_in),
    .credit_count    (credit_count),
    .credit_overflow (credit_overflow)
  );

  always #5 clk_noc = ~clk_noc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every flit the DUT presents is matched against the head of the scoreboard.
  always @(negedge clk_noc) begin
    flit_t e;
    if (send_out === 1'b1) begin
      send_cnt++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_flit: got data %0h dest %0h with empty scoreboard", data_out, dest_out);
      end else begin
        e = sb.pop_front();
        check("flit_data", 32'(data_out), 32'(e.d));
        check("flit_dest", 32'(dest_out), 32'(e.dest));
        check("flit_tail", 32'(is_tail_out), 32'(e.tail));
      end
    end
  end

  // Queue a beat on a channel; optionally record its two flits as expected output.
  task automatic enq(input int ch, input logic [31:0] d, input logic last,
                     input logic [1:0] id, input logic [1:0] td, input bit expect_flits);
    flit_t f;
    chq[ch].push_back('{data: d, last: last, tid: id, tdest: td});
    if (expect_flits) begin
      f.d = d[15:0];  f.dest = {id, td}; f.tail = 1'b0;
      sb.push_back(f);
      f.d = d[31:16]; f.dest = {id, td}; f.tail = last;
      sb.push_back(f);
    end
  endtask

  // One clock: present queue heads, credit per mode (0 none, 1 always, 2 echo send_out).
  task automatic step(input int mode);
    logic [3:0] acc;
    for (int c = 0; c < 4; c++) begin
      if (chq[c].size() > 0) begin
        s_axis_tvalid[c] = 1'b1;
        s_axis_tdata[c]  = chq[c][0].data;
        s_axis_tlast[c]  = chq[c][0].last;
        s_axis_tid[c]    = chq[c][0].tid;
        s_axis_tdest[c]  = chq[c][0].tdest;
      end else begin
        s_axis_tvalid[c] = 1'b0;
      end
    end
    credit_in = (mode == 1) ? 1'b1 : (mode == 2) ? send_out : 1'b0;
    @(negedge clk_noc);
    acc = s_axis_tvalid & s_axis_tready;
    @(posedge clk_noc);
    #1;
    for (int c = 0; c < 4; c++) if (acc[c]) void'(chq[c].pop_front());
    credit_in = 1'b0;
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n = 0;
    while ((chq[0].size() + chq[1].size() + chq[2].size() + chq[3].size() + sb.size()) != 0
           && n < max_cycles) begin
      step(2);
      n++;
    end
    if (n >= max_cycles) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d flits still expected after %0d cycles", sb.size(), n);
    end
    step(2);
    step(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_axis_tvalid = '0;
    credit_in = 1'b0;
    repeat (2) @(posedge clk_noc);
    #1;
    rst = 1'b0;
    sb.delete();
    for (int c = 0; c < 4; c++) chq[c].delete();
  endtask

  initial begin
    int s0;
    rst = 1'b1;
    s_axis_tvalid = 4'hF;
    s_axis_tdata = '0;
    s_axis_tlast = '0;
    s_axis_tid = '0;
    s_axis_tdest = '0;
    credit_in = 1'b0;
    repeat (2) @(posedge clk_noc);
    #1;
    check("rst_send", 32'(send_out), 32'd0);
    check("rst_tail", 32'(is_tail_out), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_dest", 32'(dest_out), 32'd0);
    check("rst_credit", 32'(credit_count), 32'd4);
    check("rst_ovf", 32'(credit_overflow), 32'd0);
    check("rst_tready", 32'(s_axis_tready), 32'd0);
    rst = 1'b0;
    s_axis_tvalid = '0;

    // Single-beat packet: 0xAABBCCDD -> 0xCCDD, 0xAABB, dest 0x6.
    enq(0, 32'hAABBCCDD, 1'b1, 2'd1, 2'd2, 1'b1);
    run_until_idle(40);
    check("t1_credit", 32'(credit_count), 32'd4);

    // Two competing 3-beat packets: ch1 completes before ch2 starts.
    do_reset();
    enq(1, 32'h1A2B3C4D, 1'b0, 2'd1, 2'd3, 1'b1);
    enq(1, 32'h5E6F7081, 1'b0, 2'd1, 2'd3, 1'b1);
    enq(1, 32'h92A3B4C5, 1'b1, 2'd1, 2'd3, 1'b1);
    enq(2, 32'hD1E2F3A4, 1'b0, 2'd2, 2'd3, 1'b1);
    enq(2, 32'hB5C6D7E8, 1'b0, 2'd2, 2'd3, 1'b1);
    enq(2, 32'hF9A0B1C2, 1'b1, 2'd2, 2'd3, 1'b1);
    run_until_idle(100);
    check("t2_rr_ptr", 32'(dut.rr_ptr), 32'd3);
    check("t2_state", 32'(dut.state), 32'd0);
    check("t2_credit", 32'(credit_count), 32'd4);
    check("t2_ovf", 32'(credit_overflow), 32'd0);

    // Credit exhaustion: 4 flits then stall; one credit releases exactly one flit.
    do_reset();
    enq(0, 32'h00020001, 1'b0, 2'd0, 2'd1, 1'b1);
    enq(0, 32'h00040003, 1'b0, 2'd0, 2'd1, 1'b1);
    enq(0, 32'h00060005, 1'b0, 2'd0, 2'd1, 1'b1);
    enq(0, 32'h00080007, 1'b1, 2'd0, 2'd1, 1'b1);
    s0 = send_cnt;
    repeat (12) step(0);
    check("t3_sends", 32'(send_cnt - s0), 32'd4);
    check("t3_credit0", 32'(credit_count), 32'd0);
    check("t3_tready", 32'(s_axis_tready[0]), 32'd0);
    step(1);
    repeat (4) step(0);
    check("t3_sends_after_credit", 32'(send_cnt - s0), 32'd5);
    check("t3_credit_after", 32'(credit_count), 32'd0);

    // Launch and credit return together: count and send_out steady.
    do_reset();
    enq(0, 32'h11112222, 1'b0, 2'd3, 2'd0, 1'b1);
    enq(0, 32'h33334444, 1'b0, 2'd3, 2'd0, 1'b1);
    enq(0, 32'h55556666, 1'b0, 2'd3, 2'd0, 1'b1);
    enq(0, 32'h77778888, 1'b0, 2'd3, 2'd0, 1'b1);
    enq(0, 32'h9999AAAA, 1'b0, 2'd3, 2'd0, 1'b1);
    enq(0, 32'hBBBBCCCC, 1'b1, 2'd3, 2'd0, 1'b1);
    step(0);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("t4_send", 32'(send_out), 32'd1);
      check("t4_credit", 32'(credit_count), 32'd4);
    end
    step(1);
    step(1);
    step(0);
    step(0);
    check("t4_drained", 32'(sb.size()), 32'd0);
    check("t4_credit_end", 32'(credit_count), 32'd4);
    check("t4_ovf", 32'(credit_overflow), 32'd0);

    // Overflow: a credit at full count sets the sticky flag.
    step(1);
    check("t5_ovf_set", 32'(credit_overflow), 32'd1);
    check("t5_credit_sat", 32'(credit_count), 32'd4);
    repeat (3) step(0);
    check("t5_ovf_sticky", 32'(credit_overflow), 32'd1);

    // Reset mid-packet after the first flit, then resend.
    do_reset();
    check("t6_ovf_cleared", 32'(credit_overflow), 32'd0);
    enq(0, 32'h12345678, 1'b0, 2'd0, 2'd1, 1'b0);
    enq(0, 32'h9ABCDEF0, 1'b1, 2'd0, 2'd1, 1'b0);
    sb.push_back('{d: 16'h5678, dest: 4'h1, tail: 1'b0});
    step(0);
    step(0);
    rst = 1'b1;
    #1;
    check("t6_tready_in_rst", 32'(s_axis_tready), 32'd0);
    @(posedge clk_noc);
    #1;
    check("t6_send", 32'(send_out), 32'd0);
    check("t6_credit", 32'(credit_count), 32'd4);
    check("t6_state", 32'(dut.state), 32'd0);
    check("t6_first_flit_seen", 32'(sb.size()), 32'd0);
    s_axis_tvalid = '0;
    for (int c = 0; c < 4; c++) chq[c].delete();
    @(posedge clk_noc);
    #1;
    rst = 1'b0;
    enq(0, 32'h12345678, 1'b0, 2'd0, 2'd1, 1'b1);
    enq(0, 32'h9ABCDEF0, 1'b1, 2'd0, 2'd1, 1'b1);
    run_until_idle(40);
    check("t6_credit_end", 32'(credit_count), 32'd4);
    check("t6_ovf_end", 32'(credit_overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axis_inject_mux_serializer.md
# axis_inject_mux_serializer

Multi-channel NoC injection port: arbitrates `NUM_CHANNELS` AXI-Stream sources at packet granularity, serializes each beat into `SERIALIZATION_FACTOR` flits, and drives one router input port under credit-based flow control. It sits between user AXIS masters and router input port 0 (local). It replaces the single-source serializer shim when several endpoints share one router, and it runs single-clock in the `clk_noc` domain.

## Interface
- `NUM_CHANNELS`, default 4: number of AXIS sources, at least 1.
- `TDATA_WIDTH`, default 32: AXIS beat width.
- `TID_WIDTH`, default 2: width of `tid`.
- `TDEST_WIDTH`, default 2: width of `tdest`.
- `SERIALIZATION_FACTOR`, default 2: flits per beat. Must divide `TDATA_WIDTH`.
- `FLIT_BUFFER_DEPTH`, default 4: depth of the downstream router input buffer, which is also the initial credit count.
- `FLIT_WIDTH`, derived: `TDATA_WIDTH/SERIALIZATION_FACTOR`.
- `DEST_WIDTH`, derived: `TID_WIDTH+TDEST_WIDTH`.

Ports:
- `clk_noc`, in, 1: the only clock.
- `rst`, in, 1: reset. Synchronous, active-high.
- `s_axis_tvalid`, in, `[NUM_CHANNELS]`: per-channel valid.
- `s_axis_tready`, out, `[NUM_CHANNELS]`: per-channel ready.
- `s_axis_tdata`, in, `[NUM_CHANNELS][TDATA_WIDTH]`: per-channel beat data.
- `s_axis_tlast`, in, `[NUM_CHANNELS]`: per-channel end of packet.
- `s_axis_tid`, in, `[NUM_CHANNELS][TID_WIDTH]`: per-channel `tid`.
- `s_axis_tdest`, in, `[NUM_CHANNELS][TDEST_WIDTH]`: per-channel `tdest`.
- `data_out`, out, `FLIT_WIDTH`: flit payload.
- `dest_out`, out, `DEST_WIDTH`: `{tid,tdest}` of the current beat.
- `is_tail_out`, out, 1: final flit of the packet.
- `send_out`, out, 1: flit valid. Single-cycle qualifier.
- `credit_in`, in, 1: one credit returned by the router.
- `credit_count`, out, `$clog2(FLIT_BUFFER_DEPTH+1)`: available credits.
- `credit_overflow`, out, 1: sticky error flag.

## Operation
- States:
  - IDLE: no channel owns the port.
  - LOCKED: the granted channel owns the port until its `tlast` beat has been accepted.
- Round-robin pointer `rr_ptr`, reset to 0.
- In IDLE, the winner is the first channel with `tvalid` set, searching from `rr_ptr` upward and wrapping.
- Beat register holds data, last, dest and a valid bit. Flit index `fidx` counts 0..SF-1.
- `s_axis_tready[c]` is 1 only when all three hold:
  - `c` is the winner in IDLE, or the granted channel in LOCKED.
  - The beat register is empty, or its final flit launches this cycle.
  - `rst` is 0.
- Beat acceptance (`tvalid&&tready`):
  - Load the beat register and set `fidx=0`.
  - If `tlast=0`: state becomes LOCKED with grant `c`.
  - If `tlast=1`: state becomes IDLE and `rr_ptr=(c+1) mod NUM_CHANNELS`.
- Flit launch occurs when the beat register is valid and `credit_count>0`:
  - `data_out <= beat[fidx*FLIT_WIDTH +: FLIT_WIDTH]` (LSB slice first).
  - `dest_out <= beat dest`.
  - `is_tail_out <= beat_last && fidx==SF-1`.
  - `send_out <= 1`.
  - `fidx` increments. At `fidx==SF-1` the beat register clears, unless a new beat loads in the same cycle.
- When no flit launches: `send_out <= 0`. `data_out`, `dest_out` and `is_tail_out` hold their last values.
- Credits, updated per cycle:
  - Launch only: decrement.
  - `credit_in` only: increment.
  - Both in the same cycle: unchanged.
  - `credit_in` with no launch while `credit_count==FLIT_BUFFER_DEPTH`: count saturates and `credit_overflow` sets. It clears only on `rst`.
- Packets from different channels never interleave at flit level.

## Timing
- Reset values:
  - `send_out`, `is_tail_out`, `data_out`, `dest_out`: 0.
  - `credit_count`: `FLIT_BUFFER_DEPTH`.
  - `credit_overflow`: 0.
  - `s_axis_tready`: all 0 while `rst` is high.
  - State IDLE, beat register empty.
- `rst` asserted mid-packet discards the held beat and any partial packet. No tail is emitted.
- Latency: a beat accepted at edge t has flit 0 registered at edge t+1, so `send_out` is high in the cycle after acceptance.
- Throughput with credits available: 1 flit/cycle. The next beat is accepted in the same cycle as the previous beat's final flit launches, so there is no bubble.
- A credit returned at edge t is usable for a launch at edge t+1.
- `credit_count==0` stalls launch. `fidx` and the beat register hold, and `tready` stays 0.

## Structure
- Shared package `noc_inject_pkg`:
  - State enum `inj_state_e` {IDLE, LOCKED}.
  - `FLIT_WIDTH`/`DEST_WIDTH` derivation functions.
  - Credit-width function.
- Sub-module `rr_arbiter`, parameterised by `NUM_CHANNELS`:
  - Inputs: request vector and `rr_ptr`.
  - Outputs: one-hot grant and encoded grant.
  - Purely combinational.

## Test plan
- Reset, then one single-beat packet on ch0 (`tdata=0xAABBCCDD`, `tid=1`, `tdest=2`), SF=2 → flits `0xCCDD` then `0xAABB`. `dest_out=0x6` on both; `is_tail_out` on the second only.
- Ch1 and ch2 each send a 3-beat packet, both valid from cycle 0 → all 6 of ch1's flits precede any of ch2's. `rr_ptr` ends at 3. There is no interleaving.
- `FLIT_BUFFER_DEPTH=4`, `credit_in` held 0 while ch0 streams 4 beats → exactly 4 `send_out` pulses, then a stall at `credit_count=0`. One `credit_in` pulse → exactly one more flit.
- Simultaneous launch and `credit_in` for 10 cycles → `credit_count` stays constant and `send_out` stays 1 every cycle.
- `credit_in` pulse at full credits → `credit_overflow=1`, and it stays set until `rst`.
- `rst` asserted after the first flit of a 2-beat packet → next cycle `send_out=0`, `credit_count=4`, state IDLE. The ch0 resend is then accepted normally.
